// File: rtl/crc_lut_pipe.sv
`default_nettype none
// ============================================================================
// Module   : crc_lut_pipe
// Brief    : Table-driven slicing-by-BYTES CRC engine with valid/ready on the
//            input and result sides. Lookup tables are built at elaboration
//            from POLY. Partial last beats are finished byte-serially in TAIL.
// Revision : 1.0 - initial release
// ============================================================================
module crc_lut_pipe #(
    parameter int               CRC_W  = 32,
    parameter logic [CRC_W-1:0] POLY   = 32'h04C11DB7,
    parameter logic [CRC_W-1:0] INIT   = 32'hFFFFFFFF,
    parameter logic [CRC_W-1:0] XOROUT = 32'hFFFFFFFF,
    parameter int               BYTES  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [8*BYTES-1:0]           s_data,
    input  logic                         s_sof,
    input  logic                         s_eof,
    input  logic [$clog2(BYTES):0]       s_nbytes,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [CRC_W-1:0]             m_crc,
    output logic                         busy
);

    localparam int DW   = 8 * BYTES;
    localparam int NB_W = $clog2(BYTES) + 1;
    localparam logic [NB_W-1:0] NB_FULL = NB_W'(BYTES);
    localparam logic [NB_W-1:0] NB_ZERO = '0;
    localparam logic [NB_W-1:0] NB_ONE  = NB_W'(1);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TAIL = 1'b1
    } state_t;

    // CRC contribution of byte b followed by k zero bytes (MSB-first shifting).
    function automatic logic [CRC_W-1:0] tbl_entry(input int k, input int b);
        logic [CRC_W-1:0] c;
        logic [7:0]       bb;
        bb = b[7:0];
        c  = '0;
        c[CRC_W-1 -: 8] = bb;
        for (int i = 0; i < 8 * BYTES; i++) begin
            if (i < 8 + 8 * k) begin
                c = c[CRC_W-1] ? ((c << 1) ^ POLY) : (c << 1);
            end
        end
        return c;
    endfunction

    // Slicing tables, T_k at w_tbl[k]; every entry is an elaboration-time constant.
    logic [CRC_W-1:0] w_tbl [BYTES][256];

    for (genvar k = 0; k < BYTES; k++) begin : g_tbl
        for (genvar b = 0; b < 256; b++) begin : g_ent
            localparam logic [CRC_W-1:0] ENTRY = tbl_entry(k, b);
            assign w_tbl[k][b] = ENTRY;
        end
    end

    // Registered state
    state_t           r_state;
    logic [CRC_W-1:0] r_crc;
    logic [DW-1:0]    r_shreg;
    logic [NB_W-1:0]  r_rem;
    logic             r_m_valid;
    logic [CRC_W-1:0] r_m_crc;

    // Next-state values
    state_t           w_state_n;
    logic [CRC_W-1:0] w_crc_n;
    logic [DW-1:0]    w_shreg_n;
    logic [NB_W-1:0]  w_rem_n;
    logic             w_m_valid_n;
    logic [CRC_W-1:0] w_m_crc_n;

    // Datapath intermediates
    logic             w_accept;
    logic [CRC_W-1:0] w_base;
    logic [DW-1:0]    w_x;
    logic [CRC_W-1:0] w_full;
    logic [7:0]       w_tidx;
    logic [CRC_W-1:0] w_tstep;

    assign s_ready  = (r_state == RUN) & ~(r_m_valid & ~m_ready);
    assign w_accept = s_valid & s_ready;
    assign m_valid  = r_m_valid;
    assign m_crc    = r_m_crc;
    assign busy     = (r_state == TAIL) | r_m_valid;

    // Full-beat slicing update and single-byte tail step
    always_comb begin
        w_base = s_sof ? INIT : r_crc;

        // Fold the CRC register onto the leading message bytes; bytes beyond
        // the register width are left untouched and index the tables directly.
        w_x = s_data;
        for (int i = 0; i < DW; i++) begin
            if (i < CRC_W) begin
                w_x[DW-1-i] = w_x[DW-1-i] ^ w_base[CRC_W-1-i];
            end
        end

        w_full = '0;
        if (CRC_W > DW) begin
            w_full = w_base << DW;
        end
        for (int k = 0; k < BYTES; k++) begin
            w_full = w_full ^ w_tbl[BYTES-1-k][w_x[DW-1-8*k -: 8]];
        end

        w_tidx  = r_shreg[DW-1 -: 8] ^ r_crc[CRC_W-1 -: 8];
        w_tstep = (r_crc << 8) ^ w_tbl[0][w_tidx];
    end

    // Next-state and output-register logic for RUN/TAIL
    always_comb begin
        w_state_n   = r_state;
        w_crc_n     = r_crc;
        w_shreg_n   = r_shreg;
        w_rem_n     = r_rem;
        w_m_valid_n = r_m_valid;
        w_m_crc_n   = r_m_crc;

        // Retire first so a same-edge accept can post a new result.
        if (r_m_valid && m_ready) begin
            w_m_valid_n = 1'b0;
        end

        case (r_state)
            RUN: begin
                if (w_accept) begin
                    if (!s_eof) begin
                        w_crc_n = w_full;
                    end else if (s_nbytes >= NB_FULL) begin
                        w_m_crc_n   = w_full ^ XOROUT;
                        w_m_valid_n = 1'b1;
                        w_crc_n     = INIT;
                    end else if (s_nbytes == NB_ZERO) begin
                        w_m_crc_n   = w_base ^ XOROUT;
                        w_m_valid_n = 1'b1;
                        w_crc_n     = INIT;
                    end else begin
                        // Partial beat: park data and finish byte by byte.
                        w_shreg_n = s_data;
                        w_rem_n   = s_nbytes;
                        w_crc_n   = w_base;
                        w_state_n = TAIL;
                    end
                end
            end
            TAIL: begin
                w_shreg_n = r_shreg << 8;
                w_rem_n   = r_rem - NB_ONE;
                if (r_rem <= NB_ONE) begin
                    w_m_crc_n   = w_tstep ^ XOROUT;
                    w_m_valid_n = 1'b1;
                    w_crc_n     = INIT;
                    w_rem_n     = '0;
                    w_state_n   = RUN;
                end else begin
                    w_crc_n = w_tstep;
                end
            end
            default: begin
                w_state_n = RUN;
            end
        endcase
    end

    // State register with asynchronous reset; an in-flight frame is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RUN;
            r_crc     <= INIT;
            r_shreg   <= '0;
            r_rem     <= '0;
            r_m_valid <= 1'b0;
            r_m_crc   <= '0;
        end else begin
            r_state   <= w_state_n;
            r_crc     <= w_crc_n;
            r_shreg   <= w_shreg_n;
            r_rem     <= w_rem_n;
            r_m_valid <= w_m_valid_n;
            r_m_crc   <= w_m_crc_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_lut_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_lut_pipe
// Brief    : Self-checking bench for crc_lut_pipe (defaults: CRC-32, 4 bytes
//            per beat) against a bit-serial reference CRC.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_lut_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        s_eof = 1'b0;
    logic [2:0]  s_nbytes = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_crc;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fq[$];
    logic [31:0] last_crc;

    crc_lut_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sof    (s_sof),
        .s_eof    (s_eof),
        .s_nbytes (s_nbytes),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_crc    (m_crc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-at-a-time CRC-32/BZIP2 of the bytes in fq.
    function automatic logic [31:0] ref_crc();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (fq[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[31] ^ fq[i][b];
                c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
            end
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    task automatic load_str(input string s);
        fq.delete();
        for (int i = 0; i < s.len(); i++) fq.push_back(s[i]);
    endtask

    task automatic send_beat(input logic [31:0] d, input bit sof, input bit eof, input logic [2:0] nb);
        int w;
        w = 0;
        s_data = d; s_sof = sof; s_eof = eof; s_nbytes = nb; s_valid = 1'b1;
        while (s_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 50) check("send_timeout", {63'b0, s_ready}, 64'd1);
        else begin
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0; s_data = $urandom;
    endtask

    // Send fq as 4-byte beats, then check latency, result, hold and retire.
    task automatic run_frame(input bit use_sof, input int hold, input string tag);
        int          n, idx, take, lat, exp_lat;
        bit          eof;
        logic [31:0] d, exp_crc;
        n = fq.size(); idx = 0; take = 0;
        exp_crc = ref_crc();
        m_ready = (hold == 0);
        if (n == 0) begin
            send_beat($urandom, use_sof, 1'b1, 3'd0);
        end else begin
            while (idx < n) begin
                take = (n - idx >= 4) ? 4 : (n - idx);
                d = $urandom;
                for (int j = 0; j < take; j++) d[8*(3-j) +: 8] = fq[idx+j];
                eof = (idx + take == n);
                send_beat(d, use_sof && (idx == 0), eof,
                          eof ? 3'(take) : 3'($urandom_range(0, 4)));
                idx += take;
            end
        end
        exp_lat = (n == 0 || take == 4) ? 0 : take;
        lat = 0;
        while (m_valid !== 1'b1 && lat < 20) begin
            check({tag, "_tail_busy_nready"}, {62'b0, busy, s_ready}, 64'b10);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_crc"}, {32'b0, m_crc}, {32'b0, exp_crc});
        last_crc = m_crc;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid_busy_nready"}, {61'b0, m_valid, busy, s_ready}, 64'b110);
            check({tag, "_hold_crc"}, {32'b0, m_crc}, {32'b0, exp_crc});
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_retired"}, {62'b0, m_valid, busy}, 64'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {29'b0, m_valid, busy, s_ready, m_crc}, {29'b0, 3'b001, 32'h0});
        @(negedge clk); rst = 1'b0;
        #1;
        check("post_reset_ready", {62'b0, s_ready, busy}, 64'b10);

        // CRC-32/BZIP2 check string over three beats with a 1-byte tail
        load_str("123456789");
        run_frame(1'b1, 0, "bzip2");
        check("bzip2_const", {32'b0, last_crc}, 64'hFC891918);

        // Zero-length frame, then an immediate second frame
        fq.delete();
        run_frame(1'b1, 0, "zero_len");
        check("zero_len_const", {32'b0, last_crc}, 64'h0);
        load_str("123456789");
        run_frame(1'b1, 0, "second");
        check("mpeg2_const", {32'b0, last_crc ^ 32'hFFFFFFFF}, 64'h0376E6E7);

        // Backpressure for 5 cycles, then a correct following frame
        load_str("abcdefgh");
        run_frame(1'b1, 5, "backpressure");
        load_str("123456789");
        run_frame(1'b0, 0, "after_bp");
        check("after_bp_const", {32'b0, last_crc}, 64'hFC891918);

        // 3-byte tail, reset in the second TAIL cycle drops the frame
        send_beat(32'h313233AA, 1'b1, 1'b1, 3'd3);
        check("tail_busy_c1", {62'b0, busy, s_ready}, 64'b10);
        @(posedge clk); #1;
        check("tail_busy_c2", {62'b0, busy, s_ready}, 64'b10);
        rst = 1'b1;
        #1;
        check("tail_reset_async", {29'b0, m_valid, busy, s_ready, m_crc}, {29'b0, 3'b001, 32'h0});
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("tail_reset_no_result", {61'b0, m_valid, busy, s_ready}, 64'b001);
        end
        load_str("123456789");
        run_frame(1'b1, 0, "after_reset");
        check("after_reset_const", {32'b0, last_crc}, 64'hFC891918);

        // Full-beat eof (4 bytes) and a 3-byte tail
        load_str("12345678");
        run_frame(1'b1, 0, "full_eof");
        load_str("1234567");
        run_frame(1'b1, 2, "tail3");

        // Mid-frame sof discards the first beat
        send_beat(32'h41414141, 1'b1, 1'b0, 3'd0);
        load_str("123456789");
        run_frame(1'b1, 0, "mid_sof");
        check("mid_sof_const", {32'b0, last_crc}, 64'hFC891918);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(0, 13);
            fq.delete();
            for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
            run_frame($urandom_range(0, 3) != 0,
                      ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : 0,
                      "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crc_lut_pipe.md
Name: crc_lut_pipe

Overview:
- Parametrised table-driven CRC engine; next generation of the fixed 256x32 CRC lookup tables.
- Generates its slicing-by-N tables at elaboration from POLY and processes BYTES bytes per cycle.
- Handles framing and partial last beats with a byte-serial tail FSM.
- Sits between a streaming data source and a checksum consumer, using valid/ready on both sides.

Parameters:
CRC_W, 32, CRC register width (8..64)
POLY, 32'h04C11DB7, generator polynomial, MSB-first (non-reflected), implicit top bit
INIT, 32'hFFFFFFFF, CRC register value at frame start
XOROUT, 32'hFFFFFFFF, value XORed into the final CRC
BYTES, 4, bytes per input beat (1, 2, 4 or 8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accept
s_data  in  8*BYTES  beat data; first byte is s_data[8*BYTES-1 -: 8]
s_sof  in  1  beat starts a frame; CRC register reloads INIT before this beat
s_eof  in  1  beat ends a frame
s_nbytes  in  $clog2(BYTES)+1  valid bytes on an eof beat (0..BYTES), left-justified; ignored on non-eof beats
m_valid  out  1  result valid
m_ready  in  1  result accept
m_crc  out  CRC_W  final CRC (register XOR XOROUT)
busy  out  1  high in TAIL or while m_valid is pending

Behaviour:
- Tables: T_k[b], k=0..BYTES-1. Each is the CRC_W contribution of byte b followed by k zero bytes, computed by a constant function from POLY. No hard-coded contents.
- Full-beat update: crc' = (crc << 8*BYTES) XOR over k of T_{BYTES-1-k}[byte_k XOR crc-byte_k]. This is standard slicing, done in one cycle.
  - For BYTES*8 > CRC_W, the excess leading bytes index the tables directly.
- Accept = s_valid & s_ready.
- s_ready = (state==RUN) & ~(m_valid & ~m_ready).
- FSM states: RUN (default after reset) and TAIL.
- RUN, accepted non-eof beat: crc <= update(sof ? INIT : crc).
- RUN, accepted eof beat with nbytes==BYTES:
  - On the same edge: m_crc <= update(...) XOR XOROUT, m_valid <= 1, crc <= INIT.
  - Latency is 1 cycle.
- RUN, accepted eof beat with nbytes==0:
  - m_crc <= (sof ? INIT : crc) XOR XOROUT, m_valid <= 1, crc <= INIT.
- RUN, accepted eof beat with 1 <= nbytes=k < BYTES:
  - Load shift register with s_data, set rem <= k, crc <= sof ? INIT : crc, go to TAIL.
  - No bytes are processed on the accept edge.
- TAIL, each edge:
  - crc <= (crc << 8) XOR T_0[top byte XOR crc top byte]; shift data left 8; rem--.
  - On the edge where rem goes 1->0: m_crc <= result XOR XOROUT, m_valid <= 1, crc <= INIT, go to RUN.
  - m_valid therefore rises on the k-th edge after the accept edge.
- Output handshake:
  - m_valid holds, and m_crc stays stable, until m_valid & m_ready.
  - When m_valid is pending, s_ready is low, so no beat can be accepted.
  - If m_ready is high when m_valid is set, the result retires on the next edge.
  - In that case s_ready rises in the cycle after m_valid is set.
- s_sof mid-frame discards accumulated CRC and restarts from INIT.
- An eof without any prior sof uses the current CRC register, which is INIT after reset or after the previous eof.
- Reset (asynchronous, any state including TAIL):
  - state=RUN, crc=INIT, m_valid=0, m_crc=0, rem=0.
  - s_ready=1 after reset release; busy=0.
  - An in-flight frame is dropped with no m_valid.
- Widths: all shifts are truncated to CRC_W; rem width is $clog2(BYTES)+1.
- BYTES==1: TAIL is never entered, since nbytes can only be 0 or 1.

Test Plan:
- BYTES=4, defaults. Beats "1234" (sof), "5678", "9" (eof, nbytes=1), m_ready=1 -> m_crc=32'hFC891918 (CRC-32/BZIP2 check); m_valid rises 1 edge after the third accept.
- BYTES=8, same string as "12345678" (sof) then "9" (eof, nbytes=1) -> 32'hFC891918. Repeat with BYTES=1 using 9 beats -> same value.
- Zero-length frame, sof+eof with nbytes=0 -> m_crc=32'h00000000 one edge after accept. Then an immediate second frame, "123456789" with XOROUT=0 -> 32'h0376E6E7 (CRC-32/MPEG-2).
- Backpressure: hold m_ready=0 for 5 cycles after m_valid -> m_crc stable, s_ready low throughout. After retire, the next frame's CRC is correct (started from INIT).
- Partial tail with BYTES=4, nbytes=3 on eof -> busy high and s_ready low for 3 cycles, m_valid on the 3rd edge. Assert rst during the 2nd TAIL cycle -> no m_valid, s_ready=1 after release, a new frame computes correctly.
- Mid-frame sof: send "AAAA" (sof), then "1234" (sof), "5678", "9" (eof, nbytes=1) -> 32'hFC891918, with the first beat discarded.
